// File: rtl/ram_arbiter.sv
// Two-requester (CPU / host) arbiter for a single-port 8-bit RAM, with wait-count starvation
// override, host burst locking and in-order read return. Define ARB_RR_EN for round-robin ties.
module ram_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_rvalid,
    output logic [7:0] cpu_rdata,
    output logic       cpu_stall,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    input  logic       host_lock,
    output logic       host_gnt,
    output logic       host_rvalid,
    output logic [7:0] host_rdata,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       ram_rden,
    output logic       ram_wren,
    input  logic [7:0] ram_q
);
    localparam int WW = ($clog2(MAX_WAIT + 1) < 3) ? 3 : $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);
    localparam logic [LW-1:0] LOCK_SAT = LW'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, CPU_OWN, HOST_OWN, HOST_LOCK} state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   cpu_wait_q, cpu_wait_d, host_wait_q, host_wait_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            last_host_q, last_host_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_own_q;
    logic [7:0]      cpu_rdata_q, host_rdata_q;

    logic force_rel, cpu_starve, host_starve, host_wins;

    always_comb begin
        force_rel   = (state_q == HOST_LOCK) && (lock_cnt_q == LOCK_SAT);
        cpu_starve  = (cpu_wait_q == WAIT_SAT);
        host_starve = (host_wait_q == WAIT_SAT);
        host_wins   = 1'b0;
        if (cpu_starve && host_starve)
            host_wins = ~last_host_q;
        else if (host_starve)
            host_wins = 1'b1;
        else if (cpu_starve)
            host_wins = 1'b0;
        else
`ifdef ARB_RR_EN
            host_wins = ~last_host_q;
`else
            host_wins = 1'b0;
`endif

        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (!rst) begin
            if (force_rel) begin
                cpu_gnt = cpu_req;
            end else if (state_q == HOST_LOCK && host_req) begin
                host_gnt = 1'b1;
            end else begin
                host_gnt = host_req & (~cpu_req | host_wins);
                cpu_gnt  = cpu_req & ~host_gnt;
            end
        end
    end

    always_comb begin
        state_d     = IDLE;
        lock_cnt_d  = '0;
        last_host_d = last_host_q;
        if (host_gnt) begin
            state_d     = host_lock ? HOST_LOCK : HOST_OWN;
            last_host_d = 1'b1;
            if (host_lock)
                lock_cnt_d = (state_q == HOST_LOCK) ? lock_cnt_q + 1'b1 : LW'(1);
        end else if (cpu_gnt) begin
            state_d     = CPU_OWN;
            last_host_d = 1'b0;
        end

        // CPU wait count is held while the host owns a locked burst
        if (!cpu_req || cpu_gnt)
            cpu_wait_d = '0;
        else if (state_q == HOST_LOCK || cpu_starve)
            cpu_wait_d = cpu_wait_q;
        else
            cpu_wait_d = cpu_wait_q + 1'b1;

        if (!host_req || host_gnt)
            host_wait_d = '0;
        else if (host_starve)
            host_wait_d = host_wait_q;
        else
            host_wait_d = host_wait_q + 1'b1;
    end

    always_comb begin
        ram_addr = 8'h00;
        ram_data = 8'h00;
        ram_wren = 1'b0;
        ram_rden = 1'b0;
        if (host_gnt) begin
            ram_addr = host_addr;
            ram_data = host_wdata;
            ram_wren = host_we;
            ram_rden = ~host_we;
        end else if (cpu_gnt) begin
            ram_addr = cpu_addr;
            ram_data = cpu_wdata;
            ram_wren = cpu_we;
            ram_rden = ~cpu_we;
        end
    end

    // Stale in-flight reads are masked while rst is high and flushed by it
    assign cpu_stall   = ~rst & cpu_req & ~cpu_gnt;
    assign cpu_rvalid  = ~rst & rd_vld_q[RD_LAT-1] & ~rd_own_q[RD_LAT-1];
    assign host_rvalid = ~rst & rd_vld_q[RD_LAT-1] &  rd_own_q[RD_LAT-1];
    assign cpu_rdata   = rst ? 8'h00 : (cpu_rvalid  ? ram_q : cpu_rdata_q);
    assign host_rdata  = rst ? 8'h00 : (host_rvalid ? ram_q : host_rdata_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cpu_wait_q   <= '0;
            host_wait_q  <= '0;
            lock_cnt_q   <= '0;
            last_host_q  <= 1'b1;
            rd_vld_q     <= '0;
            rd_own_q     <= '0;
            cpu_rdata_q  <= 8'h00;
            host_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cpu_wait_q  <= cpu_wait_d;
            host_wait_q <= host_wait_d;
            lock_cnt_q  <= lock_cnt_d;
            last_host_q <= last_host_d;
            rd_vld_q[0] <= ram_rden;
            rd_own_q[0] <= host_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                rd_own_q[i] <= rd_own_q[i-1];
            end
            if (cpu_rvalid)
                cpu_rdata_q <= ram_q;
            if (host_rvalid)
                host_rdata_q <= ram_q;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomised + directed bench for ram_arbiter against a cycle-level behavioural model.
module tb_ram_arbiter;
    localparam int RD_LAT = 2, MAX_WAIT = 4, LOCK_MAX = 16;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0, host_lock = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
    logic cpu_gnt, cpu_rvalid, cpu_stall, host_gnt, host_rvalid, ram_rden, ram_wren;
    logic [7:0] cpu_rdata, host_rdata, ram_addr, ram_data, ram_q;

    ram_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_rden(ram_rden), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0, 1, 2: return 8'hA0 + 8'(i);
            32'h20:  return 8'h55;
            32'h21:  return 8'h66;
            default: return 8'(i) ^ 8'h5A;
        endcase
    endfunction

    // RAM with RD_LAT-cycle read latency
    logic [7:0] mem [256];
    logic [7:0] rp [RD_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end
        rp[0] <= ram_rden ? mem[ram_addr] : 8'hEE;
        for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    end
    assign ram_q = rp[RD_LAT-1];

    typedef struct { bit we; logic [7:0] a; logic [7:0] d; bit lk; } req_t;
    typedef struct { int due; bit host; logic [7:0] d; } rd_t;
    req_t cq[$], hq[$];
    rd_t  rq[$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int m_cw = 0, m_hw = 0, m_lcnt = 0;
    bit m_lock = 0, m_last_host = 1;
    logic [7:0] m_crd = 0, m_hrd = 0;
    logic [7:0] smem [256];
    int cg = 0, hg = 0, st = 0, cvn = 0, hvn = 0, cv_cyc = 0, hv_cyc = 0;
    logic [7:0] cv_dat = 0, hv_dat = 0;
    bit last_cg = 0, last_hg = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive();
        cpu_req = (cq.size() != 0);
        if (cpu_req) begin
            cpu_we = cq[0].we; cpu_addr = cq[0].a; cpu_wdata = cq[0].d;
        end
        host_req = (hq.size() != 0);
        host_lock = 1'b0;
        if (host_req) begin
            host_we = hq[0].we; host_addr = hq[0].a; host_wdata = hq[0].d; host_lock = hq[0].lk;
        end
    endtask

    task automatic model_check();
        bit ec, eh, ecv, ehv, hw;
        logic [7:0] ea, ed;
        ec = 0; eh = 0; ecv = 0; ehv = 0; hw = 0;
        if (rst) begin
            m_cw = 0; m_hw = 0; m_lock = 0; m_lcnt = 0; m_last_host = 1;
            m_crd = 0; m_hrd = 0; rq.delete();
            for (int i = 0; i < 256; i++) smem[i] = init_byte(i);
        end else begin
            if (m_lock && m_lcnt == LOCK_MAX) ec = cpu_req;
            else if (m_lock && host_req) eh = 1;
            else if (cpu_req && host_req) begin
                if (m_hw == MAX_WAIT && m_cw == MAX_WAIT) hw = !m_last_host;
                else if (m_hw == MAX_WAIT) hw = 1;
                else if (m_cw == MAX_WAIT) hw = 0;
                else hw = RR ? !m_last_host : 1'b0;
                eh = hw; ec = !hw;
            end else begin
                ec = cpu_req; eh = host_req;
            end
            if (rq.size() != 0 && rq[0].due == cyc) begin
                if (rq[0].host) begin ehv = 1; m_hrd = rq[0].d; end
                else begin ecv = 1; m_crd = rq[0].d; end
                void'(rq.pop_front());
            end
        end
        ea = eh ? host_addr : (ec ? cpu_addr : 8'h00);
        ed = eh ? host_wdata : (ec ? cpu_wdata : 8'h00);
        chk("cpu_gnt", cpu_gnt, ec);
        chk("host_gnt", host_gnt, eh);
        chk("ram_addr", ram_addr, ea);
        chk("ram_data", ram_data, ed);
        chk("ram_wren", ram_wren, (ec && cpu_we) || (eh && host_we));
        chk("ram_rden", ram_rden, (ec && !cpu_we) || (eh && !host_we));
        chk("cpu_stall", cpu_stall, cpu_req && !ec && !rst);
        chk("cpu_rvalid", cpu_rvalid, ecv);
        chk("host_rvalid", host_rvalid, ehv);
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("host_rdata", host_rdata, m_hrd);

        last_cg = cpu_gnt; last_hg = host_gnt;
        cg += int'(cpu_gnt); hg += int'(host_gnt); st += int'(cpu_stall);
        if (cpu_rvalid)  begin cvn++; cv_cyc = cyc; cv_dat = cpu_rdata; end
        if (host_rvalid) begin hvn++; hv_cyc = cyc; hv_dat = host_rdata; end

        if (!rst) begin
            if (ec || eh) begin
                if ((ec && cpu_we) || (eh && host_we)) smem[ea] = ed;
                else rq.push_back('{due: cyc + RD_LAT, host: eh, d: smem[ea]});
            end
            if (!cpu_req || ec) m_cw = 0;
            else if (!m_lock) m_cw = (m_cw < MAX_WAIT) ? m_cw + 1 : MAX_WAIT;
            if (!host_req || eh) m_hw = 0;
            else m_hw = (m_hw < MAX_WAIT) ? m_hw + 1 : MAX_WAIT;
            m_lcnt = (eh && host_lock) ? (m_lock ? m_lcnt + 1 : 1) : 0;
            m_lock = eh && host_lock;
            if (eh) m_last_host = 1; else if (ec) m_last_host = 0;
            if (ec) void'(cq.pop_front());
            if (eh) void'(hq.pop_front());
        end
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((cq.size() != 0 || hq.size() != 0 || rq.size() != 0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 1, 0);
        step();
        step();
    endtask

    initial begin
        int g0;
        bit hlk;
        bit seq [10];
        int hfirst;

        // reset, then a read caught by a reset
        rst = 1;
        repeat (3) step();
        rst = 0;
        cq.push_back('{we: 0, a: 8'h10, d: 8'h00, lk: 0});
        step();
        rst = 1;
        step();
        step();
        rst = 0;
        cvn = 0;
        repeat (RD_LAT + 2) step();
        chk("rst_rd_drop", cvn, 0);

        // both requesting continuously
        for (int i = 0; i < 12; i++) begin
            cq.push_back('{we: 0, a: 8'(i), d: 8'h00, lk: 0});
            hq.push_back('{we: 0, a: 8'(i + 8'h30), d: 8'h00, lk: 0});
        end
        for (int k = 0; k < 10; k++) begin
            step();
            seq[k] = last_hg;
        end
        for (int k = 0; k < 10; k++)
            chk($sformatf("contend_%0d", k), seq[k], RR ? (k % 2 == 1) : (k % 5 == 4));
        drain();

        // CPU-only back-to-back reads
        cg = 0; cvn = 0;
        for (int i = 0; i < 3; i++) cq.push_back('{we: 0, a: 8'(i), d: 8'h00, lk: 0});
        drain();
        chk("cpu_only_gnts", cg, 3);
        chk("cpu_only_rvalids", cvn, 3);
        chk("cpu_only_last", cv_dat, 8'hA2);

        // host locked burst with CPU contending
        cg = 0; hg = 0; st = 0; hfirst = -1;
        for (int i = 0; i < 20; i++)
            hq.push_back('{we: 1, a: 8'(i), d: 8'($urandom), lk: 1});
        step();
        cq.push_back('{we: 0, a: 8'h40, d: 8'h00, lk: 0});
        for (int i = 0; i < 40; i++) begin
            step();
            if (last_cg && hfirst < 0) hfirst = hg;
        end
        chk("lock_host_before_cpu", hfirst, 16);
        chk("lock_cpu_gnts", cg, 1);
        chk("lock_host_gnts", hg, 20);
        chk("lock_stall_cycles", st, 15);
        drain();

        // interleaved reads of different owners
        g0 = cyc;
        cq.push_back('{we: 0, a: 8'h20, d: 8'h00, lk: 0});
        step();
        hq.push_back('{we: 0, a: 8'h21, d: 8'h00, lk: 0});
        drain();
        chk("ilv_cpu_dat", cv_dat, 8'h55);
        chk("ilv_cpu_lat", cv_cyc - g0, RD_LAT);
        chk("ilv_host_dat", hv_dat, 8'h66);
        chk("ilv_host_lat", hv_cyc - g0, RD_LAT + 1);

        // write then read the same address
        hq.push_back('{we: 1, a: 8'h80, d: 8'h3C, lk: 0});
        step();
        cq.push_back('{we: 0, a: 8'h80, d: 8'h00, lk: 0});
        drain();
        chk("wr_rd_same", cv_dat, 8'h3C);

        // randomised traffic
        hlk = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 5) hlk = ~hlk;
            if (cq.size() < 3 && $urandom_range(0, 99) < 45)
                cq.push_back('{we: 1'($urandom), a: 8'($urandom), d: 8'($urandom), lk: 0});
            if (hq.size() < 3 && $urandom_range(0, 99) < (hlk ? 90 : 35))
                hq.push_back('{we: 1'($urandom), a: 8'($urandom), d: 8'($urandom), lk: hlk});
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
